// File: rtl/seq_control_if.sv
// Opcode/phase definitions and the control-bus interface between the core datapath and seq_control.
// mem_rden/mem_wren is a request held high until the cycle mem_ready=1 completes it; there is no separate valid.
package seq_control_pkg;
    typedef logic [3:0] opcode_t;

    localparam opcode_t OPC_OP     = 4'd0;
    localparam opcode_t OPC_IMM    = 4'd1;
    localparam opcode_t OPC_LOAD   = 4'd2;
    localparam opcode_t OPC_STORE  = 4'd3;
    localparam opcode_t OPC_BRANCH = 4'd4;
    localparam opcode_t OPC_JALR   = 4'd5;
    localparam opcode_t OPC_LUI    = 4'd6;
    localparam opcode_t OPC_AUIPC  = 4'd7;
    localparam opcode_t OPC_JAL    = 4'd8;
    localparam opcode_t OPC_FENCE  = 4'd9;
    localparam opcode_t OPC_SYS    = 4'd10;

    typedef enum logic [2:0] {
        PH_C0   = 3'd0,
        PH_C1   = 3'd1,
        PH_C2   = 3'd2,
        PH_MEMR = 3'd3,
        PH_MEMW = 3'd4,
        PH_TRAP = 3'd5
    } phase_t;
endpackage

interface seq_control_if #(
    parameter int XLEN = 32,
    parameter int SW   = 5
);
    import seq_control_pkg::*;

    opcode_t           opcode;
    opcode_t           next_opcode;
    logic              mem_ready;
    logic              shift_busy;
    logic              fwd_req;
    logic [2:0]        phase;
    logic [SW-1:0]     step;
    logic              step_first;
    logic              step_last;
    logic              rf_wren;
    logic              mem_rden;
    logic              mem_wren;
    logic              fwd_taken;
    logic              instr_done;
    logic              trap;
    logic [XLEN-1:0]   instret;

    modport master (
        output opcode, next_opcode, mem_ready, shift_busy, fwd_req,
        input  phase, step, step_first, step_last, rf_wren, mem_rden, mem_wren,
               fwd_taken, instr_done, trap, instret
    );

    modport slave (
        input  opcode, next_opcode, mem_ready, shift_busy, fwd_req,
        output phase, step, step_first, step_last, rf_wren, mem_rden, mem_wren,
               fwd_taken, instr_done, trap, instret
    );
endinterface

// File: rtl/seq_control.sv
// Bit-serial core sequencer: walks each instruction through C0/C1/MEM/C2 passes of N chunk steps,
// retires it, optionally forwards straight into the prefetched next instruction, and halts on trap.
module seq_control
    import seq_control_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CHUNK  = 1,
    parameter bit FWD_EN = 1'b1
) (
    input logic          clk,
    input logic          rst,
    seq_control_if.slave bus
);
    localparam int N  = XLEN / CHUNK;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] STEP_MAX = SW'(N - 1);

    phase_t          phase_q, phase_d;
    logic [SW-1:0]   step_q, step_d;
    logic [XLEN-1:0] instret_q;
    logic            step_last;
    logic            retire;
    logic            fwd_go;
    logic            rf_wr;

    // Opcodes that need a C1 (operand/address) pass before results are written.
    function automatic logic via_c1(input opcode_t op);
        return op inside {OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
    endfunction

    function automatic logic direct_c2(input opcode_t op);
        return op inside {OPC_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL};
    endfunction

    assign step_last = (step_q == STEP_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q   <= PH_C0;
            step_q    <= '0;
            instret_q <= '0;
        end else begin
            phase_q <= phase_d;
            step_q  <= step_d;
            if (retire) instret_q <= instret_q + 1'b1;
        end
    end

    always_comb begin
        phase_d = phase_q;
        step_d  = step_q;
        retire  = 1'b0;
        fwd_go  = 1'b0;
        case (phase_q)
            PH_C0: begin
                // The fetch must complete before the pass may end; park on the last step until it does.
                if (!step_last) begin
                    step_d = step_q + 1'b1;
                end else if (bus.mem_ready) begin
                    step_d = '0;
                    if (via_c1(bus.opcode))          phase_d = PH_C1;
                    else if (direct_c2(bus.opcode))  phase_d = PH_C2;
                    else if (bus.opcode == OPC_FENCE) retire = 1'b1;
                    else                              phase_d = PH_TRAP;
                end
            end
            PH_C1: begin
                step_d = step_last ? '0 : step_q + 1'b1;
                if (step_last) begin
                    if (bus.opcode == OPC_LOAD)       phase_d = PH_MEMR;
                    else if (bus.opcode == OPC_STORE) phase_d = PH_MEMW;
                    else                              phase_d = PH_C2;
                end
            end
            PH_MEMR: begin
                step_d = '0;
                if (bus.mem_ready) phase_d = PH_C2;
            end
            PH_MEMW: begin
                step_d = '0;
                if (bus.mem_ready) retire = 1'b1;
            end
            PH_C2: begin
                step_d = step_last ? '0 : step_q + 1'b1;
                if (step_last && !bus.shift_busy) retire = 1'b1;
            end
            PH_TRAP: begin
                phase_d = PH_TRAP;
            end
            default: begin
                phase_d = PH_C0;
                step_d  = '0;
            end
        endcase

        if (retire) begin
            step_d  = '0;
            phase_d = PH_C0;
            if (FWD_EN && bus.fwd_req) begin
                if (bus.next_opcode == OPC_IMM) begin
                    phase_d = PH_C2;
                    fwd_go  = 1'b1;
                end else if (via_c1(bus.next_opcode)) begin
                    phase_d = PH_C1;
                    fwd_go  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        rf_wr = 1'b0;
        if (phase_q == PH_C0)
            rf_wr = bus.opcode inside {OPC_JAL, OPC_AUIPC};
        else if (phase_q == PH_C2)
            rf_wr = bus.opcode inside {OPC_OP, OPC_IMM, OPC_LOAD, OPC_LUI, OPC_JALR, OPC_AUIPC};
    end

    // Strobes are masked by rst directly so a reset mid-access never leaks a write.
    assign bus.rf_wren    = rf_wr & ~rst;
    assign bus.mem_rden   = ((phase_q == PH_C0) || (phase_q == PH_MEMR)) & ~rst;
    assign bus.mem_wren   = (phase_q == PH_MEMW) & ~rst;
    assign bus.fwd_taken  = fwd_go & ~rst;
    assign bus.instr_done = retire & ~rst;
    assign bus.trap       = (phase_q == PH_TRAP);
    assign bus.phase      = phase_q;
    assign bus.step       = step_q;
    assign bus.step_first = (step_q == '0);
    assign bus.step_last  = step_last;
    assign bus.instret    = instret_q;
endmodule

// File: tb/tb_seq_control.sv
// Bench for seq_control: each instruction is expanded into its expected per-cycle trace of passes,
// which also carries the inputs to drive; a negedge process compares the DUT against that trace.
module tb_seq_control;
    import seq_control_pkg::*;

    localparam int XLEN  = 32;
    localparam int CHUNK = 8;
    localparam int N     = XLEN / CHUNK;
    localparam int SW    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_control_if #(.XLEN(XLEN), .SW(SW)) bus ();
    seq_control_if #(.XLEN(XLEN), .SW(1))  bus1 ();

    seq_control #(.XLEN(XLEN), .CHUNK(CHUNK), .FWD_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    // Single-step-per-pass instance running a steady stream of IMM instructions.
    seq_control #(.XLEN(XLEN), .CHUNK(XLEN), .FWD_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct packed {
        logic          rst;
        opcode_t       opcode;
        opcode_t       next_opcode;
        logic          mem_ready;
        logic          shift_busy;
        logic          fwd_req;
        logic [2:0]    phase;
        logic [SW-1:0] step;
        logic          rf_wren;
        logic          mem_rden;
        logic          mem_wren;
        logic          fwd_taken;
        logic          instr_done;
        logic          trap;
    } cyc_t;

    cyc_t       exp_q[$];
    cyc_t       cur;
    logic       cur_valid = 1'b0;
    int         total = 0;
    int         bad = 0;
    logic [31:0] exp_instret = '0;
    logic [2:0] n1_ph = 3'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic goes_c1(input opcode_t op);
        return op inside {OPC_OP, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JALR};
    endfunction

    function automatic logic goes_c2(input opcode_t op);
        return op inside {OPC_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL};
    endfunction

    task automatic push(input logic [2:0] ph, input int st, input opcode_t op, input logic mr,
                        input logic sb, input logic rf, input logic rd, input logic wr);
        cyc_t r;
        r = '0;
        r.phase = ph; r.step = SW'(st); r.opcode = op; r.mem_ready = mr; r.shift_busy = sb;
        r.rf_wren = rf; r.mem_rden = rd; r.mem_wren = wr; r.trap = (ph == 3'd5);
        exp_q.push_back(r);
    endtask

    // Marks the most recent cycle as the retire cycle and decides where the next instruction starts.
    task automatic retire_last(input logic fwd, input opcode_t nxt, output logic [2:0] next_start);
        int  i;
        logic take;
        i = exp_q.size() - 1;
        take = fwd && (nxt == OPC_IMM || goes_c1(nxt));
        exp_q[i].instr_done  = 1'b1;
        exp_q[i].fwd_req     = fwd;
        exp_q[i].next_opcode = nxt;
        exp_q[i].fwd_taken   = take;
        next_start = !take ? 3'd0 : (nxt == OPC_IMM) ? 3'd2 : 3'd1;
    endtask

    task automatic plan_instr(input opcode_t op, input logic [2:0] start, input int c0_wait,
                              input int mem_wait, input int shifts, input logic fwd,
                              input opcode_t nxt, input bit abort_mem, output logic [2:0] next_start);
        logic rf0, rf2;
        logic [2:0] mph;
        rf0 = op inside {OPC_JAL, OPC_AUIPC};
        rf2 = op inside {OPC_OP, OPC_IMM, OPC_LOAD, OPC_LUI, OPC_JALR, OPC_AUIPC};
        next_start = 3'd0;
        if (start == 3'd0) begin
            for (int s = 0; s < N - 1; s++) push(3'd0, s, op, 1'b0, 1'b0, rf0, 1'b1, 1'b0);
            for (int w = 0; w < c0_wait; w++) push(3'd0, N - 1, op, 1'b0, 1'b0, rf0, 1'b1, 1'b0);
            push(3'd0, N - 1, op, 1'b1, 1'b0, rf0, 1'b1, 1'b0);
            if (op == OPC_FENCE) begin
                retire_last(fwd, nxt, next_start);
                return;
            end
            if (!goes_c1(op) && !goes_c2(op)) begin
                next_start = 3'd5;
                return;
            end
        end
        if (goes_c1(op) && start != 3'd2)
            for (int s = 0; s < N; s++) push(3'd1, s, op, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (op == OPC_LOAD || op == OPC_STORE) begin
            mph = (op == OPC_LOAD) ? 3'd3 : 3'd4;
            for (int w = 0; w <= mem_wait; w++) begin
                push(mph, 0, op, (w == mem_wait), 1'b0, 1'b0, op == OPC_LOAD, op == OPC_STORE);
                if (abort_mem && w == 1) begin
                    exp_q[exp_q.size() - 1].rst       = 1'b1;
                    exp_q[exp_q.size() - 1].mem_ready = 1'b0;
                    exp_q[exp_q.size() - 1].mem_rden  = 1'b0;
                    exp_q[exp_q.size() - 1].mem_wren  = 1'b0;
                    next_start = 3'd0;
                    return;
                end
            end
            if (op == OPC_STORE) begin
                retire_last(fwd, nxt, next_start);
                return;
            end
        end
        for (int p = 0; p <= shifts; p++)
            for (int s = 0; s < N; s++)
                push(3'd2, s, op, 1'b0, (s == N - 1) && (p < shifts), rf2, 1'b0, 1'b0);
        retire_last(fwd, nxt, next_start);
    endtask

    task automatic push_trap(input int n);
        for (int i = 0; i < n; i++) begin
            push(3'd5, 0, OPC_SYS, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            exp_q[exp_q.size() - 1].fwd_req     = 1'b1;
            exp_q[exp_q.size() - 1].next_opcode = OPC_OP;
        end
    endtask

    task automatic push_rst(input logic [2:0] ph, input int n);
        for (int i = 0; i < n; i++) begin
            push((i == 0) ? ph : 3'd0, 0, OPC_OP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            exp_q[exp_q.size() - 1].rst = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("phase", 32'(bus.phase), 32'(cur.phase));
            chk("step", 32'(bus.step), 32'(cur.step));
            chk("step_first", 32'(bus.step_first), 32'(cur.step == 0));
            chk("step_last", 32'(bus.step_last), 32'(cur.step == SW'(N - 1)));
            chk("rf_wren", 32'(bus.rf_wren), 32'(cur.rf_wren));
            chk("mem_rden", 32'(bus.mem_rden), 32'(cur.mem_rden));
            chk("mem_wren", 32'(bus.mem_wren), 32'(cur.mem_wren));
            chk("fwd_taken", 32'(bus.fwd_taken), 32'(cur.fwd_taken));
            chk("instr_done", 32'(bus.instr_done), 32'(cur.instr_done));
            chk("trap", 32'(bus.trap), 32'(cur.trap));
            chk("instret", bus.instret, exp_instret);
            if (cur.rst) exp_instret = '0;
            else if (cur.instr_done) exp_instret = exp_instret + 1;

            if (!cur.rst) begin
                chk("n1_phase", 32'(bus1.phase), 32'(n1_ph));
                chk("n1_first_last", 32'({bus1.step_first, bus1.step_last}), 32'd3);
                chk("n1_instr_done", 32'(bus1.instr_done), 32'(n1_ph == 3'd2));
            end
            n1_ph = cur.rst ? 3'd0 : (n1_ph == 3'd0) ? 3'd2 : 3'd0;
        end
    end

    initial begin
        int b;
        logic [2:0] ns;
        bus.opcode = OPC_OP; bus.next_opcode = OPC_OP;
        bus.mem_ready = 1'b0; bus.shift_busy = 1'b0; bus.fwd_req = 1'b0;
        bus1.opcode = OPC_IMM; bus1.next_opcode = OPC_OP;
        bus1.mem_ready = 1'b1; bus1.shift_busy = 1'b0; bus1.fwd_req = 1'b0;

        b = exp_q.size(); plan_instr(OPC_IMM, 3'd0, 0, 0, 0, 1'b0, OPC_OP, 0, ns);
        chk("len_addi", exp_q.size() - b, 8);
        b = exp_q.size(); plan_instr(OPC_LOAD, ns, 0, 3, 0, 1'b0, OPC_OP, 0, ns);
        chk("len_lw", exp_q.size() - b, 16);
        b = exp_q.size(); plan_instr(OPC_IMM, ns, 2, 0, 2, 1'b0, OPC_OP, 0, ns);
        chk("len_slli", exp_q.size() - b, 18);
        b = exp_q.size(); plan_instr(OPC_STORE, ns, 0, 1, 0, 1'b1, OPC_OP, 0, ns);
        chk("len_sw", exp_q.size() - b, 10);
        chk("fwd_sw_to_c1", 32'(ns), 32'd1);
        b = exp_q.size(); plan_instr(OPC_OP, ns, 0, 0, 0, 1'b1, OPC_IMM, 0, ns);
        chk("len_add_fwd", exp_q.size() - b, 8);
        chk("fwd_add_to_c2", 32'(ns), 32'd2);
        b = exp_q.size(); plan_instr(OPC_IMM, ns, 0, 0, 0, 1'b1, OPC_LUI, 0, ns);
        chk("len_addi_fwd", exp_q.size() - b, 4);
        chk("no_fwd_lui", 32'(ns), 32'd0);
        plan_instr(OPC_LUI, ns, 1, 0, 0, 1'b0, OPC_OP, 0, ns);
        plan_instr(OPC_JAL, ns, 0, 0, 0, 1'b1, OPC_SYS, 0, ns);
        plan_instr(OPC_AUIPC, ns, 0, 0, 1, 1'b0, OPC_OP, 0, ns);
        plan_instr(OPC_BRANCH, ns, 0, 0, 0, 1'b1, OPC_JALR, 0, ns);
        plan_instr(OPC_JALR, ns, 0, 0, 0, 1'b0, OPC_OP, 0, ns);
        b = exp_q.size(); plan_instr(OPC_FENCE, ns, 0, 0, 0, 1'b1, OPC_STORE, 0, ns);
        chk("len_fence", exp_q.size() - b, 4);
        plan_instr(OPC_STORE, ns, 0, 3, 0, 1'b0, OPC_OP, 1, ns);
        b = exp_q.size(); plan_instr(OPC_SYS, ns, 0, 0, 0, 1'b0, OPC_OP, 0, ns);
        chk("len_ecall", exp_q.size() - b, 4);
        chk("ecall_traps", 32'(ns), 32'd5);
        push_trap(5);
        push_rst(3'd5, 2);
        plan_instr(4'hF, 3'd0, 0, 0, 0, 1'b0, OPC_OP, 0, ns);
        push_trap(3);
        push_rst(3'd5, 1);
        plan_instr(OPC_IMM, 3'd0, 0, 0, 0, 1'b0, OPC_OP, 0, ns);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", 32'(bus.phase), 32'd0);
        chk("rst_step", 32'(bus.step), 32'd0);
        chk("rst_trap", 32'(bus.trap), 32'd0);
        chk("rst_instret", bus.instret, 32'd0);
        chk("rst_mem_rden", 32'(bus.mem_rden), 32'd0);
        chk("rst_rf_wren", 32'(bus1.rf_wren | bus.rf_wren), 32'd0);
        chk("rst_instr_done", 32'(bus.instr_done | bus1.instr_done), 32'd0);

        @(posedge clk); #1;
        rst = 1'b0;
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            rst = cur.rst;
            bus.opcode = cur.opcode;
            bus.next_opcode = cur.next_opcode;
            bus.mem_ready = cur.mem_ready;
            bus.shift_busy = cur.shift_busy;
            bus.fwd_req = cur.fwd_req;
            cur_valid = 1'b1;
            @(posedge clk); #1;
        end
        cur_valid = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
